// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache sitting
// between the memory stage and an SRAM controller that returns 64-bit blocks.
module cache_controller #(
  parameter logic [31:0] DATA_BASE = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Read_En,
  input  logic        Write_En,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
);

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

  state_t      state;

  logic [31:0] offset;
  logic        word_sel;
  logic [5:0]  set_idx;
  logic [9:0]  tag;
  logic [31:0] block_addr;
  logic        unused_offset_bits;

  logic [63:0] valid0;
  logic [63:0] valid1;
  logic [63:0] lru;
  logic [9:0]  tag0  [64];
  logic [9:0]  tag1  [64];
  logic [63:0] data0 [64];
  logic [63:0] data1 [64];

  logic        rd_req;
  logic        wr_req;
  logic        hit0;
  logic        hit1;
  logic        hit;
  logic        hit_way;
  logic        victim;
  logic [63:0] hit_block;

  // Word index relative to the data segment: bit 2 picks the word, then set, then tag.
  assign offset             = address - DATA_BASE;
  assign word_sel           = offset[2];
  assign set_idx            = offset[8:3];
  assign tag                = offset[18:9];
  assign block_addr         = {offset[31:3], 3'b000} + DATA_BASE;
  assign unused_offset_bits = ^offset[1:0];

  assign rd_req = Read_En & ~Write_En;
  assign wr_req = Write_En;

  assign hit0      = valid0[set_idx] && (tag0[set_idx] == tag);
  assign hit1      = valid1[set_idx] && (tag1[set_idx] == tag);
  assign hit       = hit0 | hit1;
  assign hit_way   = ~hit0;
  assign hit_block = hit0 ? data0[set_idx] : data1[set_idx];

  // Fill an empty way before evicting; way0 is taken first when both are empty.
  assign victim = !valid0[set_idx] ? 1'b0 :
                  !valid1[set_idx] ? 1'b1 : lru[set_idx];

  always_comb begin
    ready    = 1'b1;
    readData = word_sel ? hit_block[63:32] : hit_block[31:0];
    case (state)
      IDLE: begin
        if (wr_req)
          ready = 1'b0;
        else if (rd_req)
          ready = hit;
      end
      RD_MISS: begin
        ready    = sram_ready;
        readData = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
      end
      WR_THRU: ready = sram_ready;
      default: ready = 1'b1;
    endcase
    if (!rst)
      ready = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      sram_rd_en   <= 1'b0;
      sram_wr_en   <= 1'b0;
      sram_address <= '0;
      sram_wdata   <= '0;
      valid0       <= '0;
      valid1       <= '0;
      lru          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_req) begin
            state        <= WR_THRU;
            sram_wr_en   <= 1'b1;
            sram_address <= address;
            sram_wdata   <= writeData;
          end else if (rd_req) begin
            if (hit) begin
              lru[set_idx] <= ~hit_way;
            end else begin
              state        <= RD_MISS;
              sram_rd_en   <= 1'b1;
              sram_address <= block_addr;
            end
          end
        end
        RD_MISS: begin
          if (sram_ready) begin
            state      <= IDLE;
            sram_rd_en <= 1'b0;
            if (victim)
              valid1[set_idx] <= 1'b1;
            else
              valid0[set_idx] <= 1'b1;
            lru[set_idx] <= ~victim;
          end
        end
        WR_THRU: begin
          if (sram_ready) begin
            state      <= IDLE;
            sram_wr_en <= 1'b0;
            if (hit)
              lru[set_idx] <= ~hit_way;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data storage is never cleared; reset forces IDLE so no write can slip through.
  always_ff @(posedge clk) begin
    if (state == RD_MISS && sram_ready) begin
      if (victim) begin
        tag1[set_idx]  <= tag;
        data1[set_idx] <= sram_rdata;
      end else begin
        tag0[set_idx]  <= tag;
        data0[set_idx] <= sram_rdata;
      end
    end else if (state == WR_THRU && sram_ready && hit) begin
      if (hit_way) begin
        if (word_sel) data1[set_idx][63:32] <= writeData;
        else          data1[set_idx][31:0]  <= writeData;
      end else begin
        if (word_sel) data0[set_idx][63:32] <= writeData;
        else          data0[set_idx][31:0]  <= writeData;
      end
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: directed vector table, reset/idle corner sequences,
// and random traffic checked against an LRU-list cache model plus an SRAM memory model.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        Read_En;
  logic        Write_En;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ready;
  logic        sram_rd_en;
  logic        sram_wr_en;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [logic [31:0]];

  int         m_cnt  [64];
  logic [9:0] m_list [64][2];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        exp_hit;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [14];

  cache_controller #(.DATA_BASE(32'd1024)) dut (
    .clk(clk), .rst(rst), .Read_En(Read_En), .Write_En(Write_En),
    .address(address), .writeData(writeData), .readData(readData), .ready(ready),
    .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_address(sram_address),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] k;
    k = a >> 2;
    if (mem.exists(k)) return mem[k];
    return 32'hC0DE_0000 | {16'h0, k[15:0]};
  endfunction

  task automatic check_output(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One complete request: issue, wait lat cycles for SRAM if it misses or writes, release.
  task automatic apply_stimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input int lat, input logic exp_hit,
                                input logic [31:0] exp_data, input string nm);
    logic [31:0] blk;
    blk = ((addr - 32'd1024) & ~32'h7) + 32'd1024;
    @(negedge clk);
    Read_En = rd; Write_En = wr; address = addr; writeData = wdata; sram_ready = 1'b0;
    #1;
    if (!wr && exp_hit) begin
      check_output({nm, " hit ready"}, ready, 1);
      check_output({nm, " hit data"}, readData, exp_data);
      check_output({nm, " hit no sram"}, {sram_rd_en, sram_wr_en}, 0);
    end else begin
      check_output({nm, " first ready"}, ready, 0);
      check_output({nm, " first sram"}, {sram_rd_en, sram_wr_en}, 0);
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk);
        sram_ready = (k == lat);
        sram_rdata = {mem_word(blk + 32'd4), mem_word(blk)};
        #1;
        if (wr) begin
          check_output({nm, " wr en"}, {sram_rd_en, sram_wr_en}, 2'b01);
          check_output({nm, " wr addr"}, sram_address, addr);
          check_output({nm, " wr data"}, sram_wdata, wdata);
        end else begin
          check_output({nm, " rd en"}, {sram_rd_en, sram_wr_en}, 2'b10);
          check_output({nm, " rd addr"}, sram_address, blk);
        end
        check_output({nm, " ready"}, ready, (k == lat));
        if (k == lat && !wr) check_output({nm, " fill data"}, readData, exp_data);
        if (k == lat && wr) mem[addr >> 2] = wdata;
      end
    end
    @(negedge clk);
    Read_En = 1'b0; Write_En = 1'b0; sram_ready = 1'b0;
    #1;
    check_output({nm, " idle ready"}, ready, 1);
    check_output({nm, " idle sram"}, {sram_rd_en, sram_wr_en}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("reset ready", ready, 1);
    check_output("reset sram", {sram_rd_en, sram_wr_en}, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int s = 0; s < 64; s++) m_cnt[s] = 0;
  endtask

  // Recency list per set: entry 0 is least recently used.
  function automatic logic model_lookup(input int s, input logic [9:0] t);
    for (int i = 0; i < m_cnt[s]; i++)
      if (m_list[s][i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_touch(input int s, input logic [9:0] t);
    if (m_cnt[s] == 2 && m_list[s][0] == t) begin
      m_list[s][0] = m_list[s][1];
      m_list[s][1] = t;
    end
  endtask

  task automatic model_fill(input int s, input logic [9:0] t);
    if (m_cnt[s] < 2) begin
      m_list[s][m_cnt[s]] = t;
      m_cnt[s]++;
    end else begin
      m_list[s][0] = m_list[s][1];
      m_list[s][1] = t;
    end
  endtask

  initial begin
    logic [31:0] a, w, ed;
    logic        r, wr, h;
    int          s, lat;
    logic [9:0]  t;

    rst = 1'b0; Read_En = 1'b1; Write_En = 1'b0; address = 32'd1024;
    writeData = '0; sram_rdata = '0; sram_ready = 1'b0;
    mem[32'd256] = 32'd1;
    mem[32'd257] = 32'd2;
    #2;
    check_output("reset ready with request", ready, 1);
    check_output("reset sram idle", {sram_rd_en, sram_wr_en}, 0);
    Read_En = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    vecs[0]  = '{1'b1, 1'b0, 32'd1024, 32'h0,         3, 1'b0, 32'd1};
    vecs[1]  = '{1'b1, 1'b0, 32'd1028, 32'h0,         0, 1'b1, 32'd2};
    vecs[2]  = '{1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, 2, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'd1024, 32'h0,         0, 1'b1, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 1'b1, 32'd2048, 32'h1234_5678, 1, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 32'd2048, 32'h0,         2, 1'b0, 32'h1234_5678};
    vecs[6]  = '{1'b1, 1'b0, 32'd1024, 32'h0,         0, 1'b1, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b1, 1'b0, 32'd1536, 32'h0,         1, 1'b0, 32'hC0DE_0180};
    vecs[8]  = '{1'b1, 1'b0, 32'd1024, 32'h0,         0, 1'b1, 32'hDEAD_BEEF};
    vecs[9]  = '{1'b1, 1'b0, 32'd2560, 32'h0,         2, 1'b0, 32'hC0DE_0280};
    vecs[10] = '{1'b1, 1'b0, 32'd1024, 32'h0,         0, 1'b1, 32'hDEAD_BEEF};
    vecs[11] = '{1'b1, 1'b0, 32'd1536, 32'h0,         1, 1'b0, 32'hC0DE_0180};
    vecs[12] = '{1'b1, 1'b1, 32'd1024, 32'hCAFE_0001, 2, 1'b1, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 32'd1024, 32'h0,         0, 1'b1, 32'hCAFE_0001};

    for (int i = 0; i < 14; i++)
      apply_stimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].lat,
                     vecs[i].exp_hit, vecs[i].exp_data, $sformatf("vec%0d", i));

    // Reset dropped in the middle of a miss must abort it and empty the cache.
    @(negedge clk);
    Read_En = 1'b1; address = 32'd3072;
    #1;
    check_output("abort first ready", ready, 0);
    @(negedge clk);
    #1;
    check_output("abort in miss", sram_rd_en, 1);
    #2;
    rst = 1'b0;
    #1;
    check_output("abort rd_en drop", sram_rd_en, 0);
    check_output("abort ready", ready, 1);
    @(negedge clk);
    Read_En = 1'b0; rst = 1'b1;
    apply_stimulus(1'b1, 1'b0, 32'd3072, 32'h0, 1, 1'b0, mem_word(32'd3072), "reread aborted");
    apply_stimulus(1'b1, 1'b0, 32'd1024, 32'h0, 2, 1'b0, 32'hCAFE_0001, "cold after reset");

    // A stray completion pulse while idle must not start or disturb anything.
    @(negedge clk);
    sram_ready = 1'b1;
    #1;
    check_output("stray pulse ready", ready, 1);
    @(negedge clk);
    sram_ready = 1'b0;
    #1;
    check_output("stray pulse sram", {sram_rd_en, sram_wr_en}, 0);
    apply_stimulus(1'b1, 1'b0, 32'd1024, 32'h0, 0, 1'b1, 32'hCAFE_0001, "hit after stray");

    do_reset();
    for (int n = 0; n < 200; n++) begin
      int op;
      op  = $urandom_range(0, 9);
      r   = (op < 6) || (op == 9);
      wr  = (op >= 6);
      t   = 10'($urandom_range(0, 3));
      s   = $urandom_range(0, 3);
      a   = 32'd1024 + ({22'h0, t} << 9) + (32'(s) << 3) + (32'($urandom_range(0, 1)) << 2);
      w   = $urandom;
      lat = $urandom_range(1, 3);
      s   = int'(((a - 32'd1024) >> 3) & 32'h3F);
      t   = 10'((a - 32'd1024) >> 9);
      h   = model_lookup(s, t);
      ed  = mem_word(a);
      apply_stimulus(r, wr, a, w, lat, h, ed, $sformatf("rand%0d", n));
      if (h) model_touch(s, t);
      else if (!wr) model_fill(s, t);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
